as_sequencer: RTL and testbench

//  Multi-cycle fetch/decode/execute controller for the accumulator datapath (ALU, ACC, register file).

---
 rtl/as_sequencer.sv | 148 ++++++++++++++
 tb/tb_as_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/as_sequencer.sv
// Fetch/decode/execute controller for the accumulator datapath: 3 cycles/instruction on a zero-wait fetch.
// Stalls in FETCH until imem_ack and in IN_WAIT until sw_valid; HALT is terminal until reset.
module as_sequencer #(
  parameter int n   = 8,
  parameter int PCW = 8,
  parameter int IW  = 16
) (
  input  logic           clk,
  input  logic           n_reset,
  output logic           imem_req,
  output logic [PCW-1:0] imem_addr,
  input  logic           imem_ack,
  input  logic [IW-1:0]  imem_data,
  output logic [1:0]     rd_addr,
  output logic [1:0]     rs_addr,
  output logic           reg_we,
  output logic [n-1:0]   alu_imm,
  output logic           add_a_sel,
  output logic           add_b_sel,
  output logic           acc_en,
  output logic           acc_add,
  output logic           in_en,
  input  logic           z,
  input  logic           sw_valid,
  output logic           sw_ack,
  output logic           halted,
  output logic           illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_IN_WAIT, S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_MULA = 4'h2;
  localparam logic [3:0] OP_ACCM = 4'h3;
  localparam logic [3:0] OP_IN   = 4'h4;
  localparam logic [3:0] OP_BZ   = 4'h5;
  localparam logic [3:0] OP_BSW  = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t         state, state_n;
  logic [PCW-1:0] pc, pc_n, pc_inc, target;
  logic [IW-1:0]  ir, ir_n;
  logic           illegal_n;
  logic [3:0]     op;
  logic signed [7:0] imm_s;

  assign op        = ir[15:12];
  assign imm_s     = ir[7:0];
  assign pc_inc    = pc + PCW'(1);
  assign target    = PCW'(ir[7:0]);
  assign imem_addr = pc;
  assign rd_addr   = ir[11:10];
  assign rs_addr   = ir[9:8];
  assign halted    = (state == S_HALT);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state   <= S_IDLE;
      pc      <= '0;
      ir      <= '0;
      illegal <= 1'b0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      ir      <= ir_n;
      illegal <= illegal_n;
    end
  end

  // All strobes are decoded from the current state so a reset kills them immediately.
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    ir_n      = ir;
    illegal_n = illegal;
    imem_req  = 1'b0;
    reg_we    = 1'b0;
    alu_imm   = '0;
    add_a_sel = 1'b0;
    add_b_sel = 1'b0;
    acc_en    = 1'b0;
    acc_add   = 1'b0;
    in_en     = 1'b0;
    sw_ack    = 1'b0;
    case (state)
      S_IDLE: state_n = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_n    = imem_data;
          state_n = S_DECODE;
        end
      end
      S_DECODE: state_n = (op == OP_IN) ? S_IN_WAIT : S_EXEC;
      S_EXEC: begin
        alu_imm = n'(imm_s);
        state_n = S_FETCH;
        pc_n    = pc_inc;
        case (op)
          OP_NOP, OP_IN: ;
          OP_ADDI: begin
            add_b_sel = 1'b1;
            reg_we    = 1'b1;
          end
          OP_MULA: reg_we = 1'b1;
          OP_ACCM: begin
            acc_add = 1'b1;
            acc_en  = 1'b1;
          end
          OP_BZ: begin
            alu_imm   = '0;
            add_b_sel = 1'b1;
            if (z) pc_n = target;
          end
          // z low means SW[8] was set, so the switch branch is taken.
          OP_BSW: begin
            alu_imm   = '0;
            add_a_sel = 1'b1;
            add_b_sel = 1'b1;
            if (!z) pc_n = target;
          end
          OP_JMP: pc_n = target;
          OP_HALT: begin
            pc_n    = pc;
            state_n = S_HALT;
          end
          default: illegal_n = 1'b1;
        endcase
      end
      S_IN_WAIT: begin
        if (sw_valid) begin
          in_en   = 1'b1;
          reg_we  = 1'b1;
          sw_ack  = 1'b1;
          pc_n    = pc_inc;
          state_n = S_FETCH;
        end
      end
      S_HALT: ;
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_as_sequencer.sv
// Directed bench for as_sequencer: fetch timing, IN handshake, branches, wrap, illegal flag, mid-EXEC reset.
module tb_as_sequencer;
  logic        clk = 1'b0;
  logic        n_reset;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [1:0]  rd_addr, rs_addr;
  logic        reg_we;
  logic [7:0]  alu_imm;
  logic        add_a_sel, add_b_sel, acc_en, acc_add, in_en;
  logic        z, sw_valid, sw_ack, halted, illegal;

  int checks = 0;
  int errors = 0;

  as_sequencer dut (
    .clk(clk), .n_reset(n_reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .rd_addr(rd_addr), .rs_addr(rs_addr), .reg_we(reg_we), .alu_imm(alu_imm),
    .add_a_sel(add_a_sel), .add_b_sel(add_b_sel), .acc_en(acc_en), .acc_add(acc_add),
    .in_en(in_en), .z(z), .sw_valid(sw_valid), .sw_ack(sw_ack),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Leaves the DUT in IDLE, one edge before FETCH.
  task automatic do_reset();
    n_reset   = 1'b0;
    imem_ack  = 1'b0;
    imem_data = 16'h0000;
    sw_valid  = 1'b0;
    z         = 1'b0;
    tick();
    tick();
    n_reset = 1'b1;
  endtask

  // Called in FETCH; returns in DECODE.
  task automatic fetch(input logic [15:0] instr);
    imem_data = instr;
    imem_ack  = 1'b1;
    tick();
    imem_ack  = 1'b0;
  endtask

  initial begin
    // 1: ADDI r1,5 ; HALT with ack tied high
    n_reset = 1'b0;
    imem_ack = 1'b0; imem_data = '0; sw_valid = 1'b0; z = 1'b0;
    #2;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_strobes", {reg_we, acc_en, in_en, sw_ack, add_a_sel, add_b_sel, acc_add}, 0);
    do_reset();
    imem_ack = 1'b1; imem_data = 16'h1405;
    chk("t1_idle_req", imem_req, 0);
    tick();
    chk("t1_fetch_req", imem_req, 1);
    tick();
    imem_data = 16'hF000;
    chk("t1_dec_rd", rd_addr, 1);
    chk("t1_dec_we", reg_we, 0);
    tick();
    chk("t1_exec_we", reg_we, 1);
    chk("t1_exec_rd", rd_addr, 1);
    chk("t1_exec_imm", alu_imm, 8'h05);
    chk("t1_exec_bsel", add_b_sel, 1);
    tick();
    chk("t1_fetch2_addr", imem_addr, 1);
    chk("t1_fetch2_we", reg_we, 0);
    tick();
    tick();
    chk("t1_halt_exec", halted, 0);
    tick();
    chk("t1_halted", halted, 1);
    chk("t1_halt_pc", imem_addr, 1);
    repeat (3) tick();
    chk("t1_halt_stay", {halted, imem_req}, 2'b10);
    imem_ack = 1'b0;

    // 2: delayed ack; ir captured only on the ack cycle
    do_reset();
    tick();
    imem_data = 16'h1F00;
    for (int i = 0; i < 3; i++) begin
      chk("t2_wait_req", {imem_req, imem_addr}, 9'h100);
      tick();
    end
    chk("t2_ack_req", {imem_req, imem_addr}, 9'h100);
    fetch(16'h2907);
    imem_ack = 1'b1;
    chk("t2_dec_regs", {rd_addr, rs_addr}, 4'b1001);
    tick();
    imem_ack = 1'b0;
    chk("t2_exec_mula", {reg_we, add_b_sel, alu_imm}, 10'h207);
    tick();
    chk("t2_next_addr", imem_addr, 1);

    // 3: IN r2, sw_valid after 5 wait cycles
    do_reset();
    tick();
    fetch(16'h4800);
    tick();
    chk("t3_wait_quiet", {in_en, reg_we, sw_ack}, 0);
    repeat (4) tick();
    chk("t3_wait_quiet5", {in_en, reg_we, sw_ack}, 0);
    sw_valid = 1'b1;
    #1;
    chk("t3_sw_cycle", {in_en, reg_we, sw_ack}, 3'b111);
    chk("t3_rd", rd_addr, 2);
    tick();
    chk("t3_single_pulse", {in_en, reg_we, sw_ack}, 0);
    chk("t3_next_addr", {imem_req, imem_addr}, 9'h101);
    sw_valid = 1'b0;

    // 4: BZ taken / not taken, BSW taken
    do_reset();
    tick();
    fetch(16'h5010);
    z = 1'b1;
    tick();
    chk("t4_bz_exec", {alu_imm, add_b_sel, reg_we}, 10'h002);
    tick();
    z = 1'b0;
    chk("t4_bz_taken", imem_addr, 8'h10);
    fetch(16'h5020);
    tick();
    tick();
    chk("t4_bz_not_taken", imem_addr, 8'h11);
    fetch(16'h6040);
    tick();
    chk("t4_bsw_exec", {add_a_sel, add_b_sel, alu_imm}, 10'h300);
    tick();
    chk("t4_bsw_taken", imem_addr, 8'h40);

    // 5: wrap via JMP and NOP at 0xFF; sticky illegal
    fetch(16'h70FF);
    tick();
    tick();
    chk("t5_jmp_ff", imem_addr, 8'hFF);
    fetch(16'h7000);
    tick();
    tick();
    chk("t5_jmp_wrap", imem_addr, 8'h00);
    fetch(16'h70FF);
    tick();
    tick();
    fetch(16'h0000);
    tick();
    tick();
    chk("t5_nop_wrap", imem_addr, 8'h00);
    fetch(16'hA123);
    tick();
    chk("t5_illegal_exec", {illegal, reg_we, acc_en}, 0);
    tick();
    chk("t5_illegal_set", illegal, 1);
    chk("t5_illegal_pc", imem_addr, 1);
    fetch(16'h1405);
    tick();
    tick();
    chk("t5_illegal_sticky", {illegal, imem_addr}, 9'h102);

    // 6: reset during ACCM EXEC
    do_reset();
    chk("t6_illegal_cleared", illegal, 0);
    tick();
    fetch(16'h7033);
    tick();
    tick();
    chk("t6_at_33", imem_addr, 8'h33);
    fetch(16'h3103);
    tick();
    chk("t6_accm_exec", {acc_en, acc_add, reg_we, alu_imm}, 11'h603);
    n_reset = 1'b0;
    #1;
    chk("t6_abort", {acc_en, acc_add, reg_we, alu_imm}, 0);
    chk("t6_abort_pc", imem_addr, 0);
    tick();
    n_reset = 1'b1;
    chk("t6_idle", imem_req, 0);
    tick();
    chk("t6_refetch", {imem_req, imem_addr}, 9'h100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
